// File: rtl/quad_mux_arb_pkg.sv
// Shared types for the quad 2-to-1 multiplexer arbiter: FSM states and owner encoding.
package quad_mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        OWN_A = 2'd2,
        OWN_B = 2'd3
    } arb_state_e;

    // Owner codes double as the multiplexer select value.
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/arb_hold_counter.sv
// Counts consecutive grant cycles of the current owner, saturating at HOLD_MAX-1.
module arb_hold_counter #(
    parameter int HOLD_MAX = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic at_limit_o
);

    localparam int W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [W-1:0] LIMIT = W'(HOLD_MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_limit_o = (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !at_limit_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quad_mux_arbiter.sv
// Round-robin owner arbitration for a shared quad 2-to-1 mux, with a hold limit
// and one disabled guard cycle on every change of owner. All outputs registered.
module quad_mux_arbiter
    import quad_mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_A,
    input  logic       REQ_B,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic       S,
    output logic       E,
    output logic [1:0] dbg_state_o
);

    arb_state_e state_q, state_d;
    logic next_q, next_d;
    logic last_q, last_d;
    logic s_q, s_d;
    logic e_q, e_d;
    logic gnt_a_q, gnt_a_d;
    logic gnt_b_q, gnt_b_d;
    logic in_own;
    logic at_limit;

    assign in_own = (state_q == OWN_A) || (state_q == OWN_B);

    // Every OWN state is entered from GUARD, so clearing outside OWN clears on entry.
    arb_hold_counter #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clear_i    (!in_own),
        .enable_i   (in_own),
        .at_limit_o (at_limit)
    );

    always_comb begin
        state_d = state_q;
        next_d  = next_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (REQ_A && REQ_B) begin
                    next_d  = (last_q == OWNER_A) ? OWNER_B : OWNER_A;
                    state_d = GUARD;
                end else if (REQ_A) begin
                    next_d  = OWNER_A;
                    state_d = GUARD;
                end else if (REQ_B) begin
                    next_d  = OWNER_B;
                    state_d = GUARD;
                end
            end
            GUARD: begin
                if ((next_q == OWNER_A) ? REQ_A : REQ_B) begin
                    state_d = (next_q == OWNER_A) ? OWN_A : OWN_B;
                    last_d  = next_q;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_A: begin
                if (!REQ_A) begin
                    state_d = REQ_B ? GUARD : IDLE;
                    next_d  = OWNER_B;
                end else if (REQ_B && at_limit) begin
                    state_d = GUARD;
                    next_d  = OWNER_B;
                end
            end
            OWN_B: begin
                if (!REQ_B) begin
                    state_d = REQ_A ? GUARD : IDLE;
                    next_d  = OWNER_A;
                end else if (REQ_A && at_limit) begin
                    state_d = GUARD;
                    next_d  = OWNER_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        s_d     = s_q;
        e_d     = 1'b1;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        case (state_d)
            GUARD: s_d = next_d;
            OWN_A: begin
                s_d     = OWNER_A;
                e_d     = 1'b0;
                gnt_a_d = 1'b1;
            end
            OWN_B: begin
                s_d     = OWNER_B;
                e_d     = 1'b0;
                gnt_b_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            next_q  <= OWNER_A;
            last_q  <= OWNER_B;
            s_q     <= 1'b0;
            e_q     <= 1'b1;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            last_q  <= last_d;
            s_q     <= s_d;
            e_q     <= e_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
        end
    end

    assign GNT_A       = gnt_a_q;
    assign GNT_B       = gnt_b_q;
    assign S           = s_q;
    assign E           = e_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_quad_mux_arbiter.sv
// Directed bench for quad_mux_arbiter: three instances (HOLD_MAX 8, 1, 3) checked
// against hand-computed per-cycle expectations plus continuous output invariants.
module tb_quad_mux_arbiter;
    import quad_mux_arb_pkg::*;

    // Expected output nibble: {GNT_A, GNT_B, S, E}
    localparam logic [3:0] X_S0 = 4'b0001;
    localparam logic [3:0] X_S1 = 4'b0011;
    localparam logic [3:0] X_A  = 4'b1000;
    localparam logic [3:0] X_B  = 4'b0110;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req_a;
    logic [2:0] req_b;
    logic [2:0] gnt_a;
    logic [2:0] gnt_b;
    logic [2:0] s;
    logic [2:0] e;
    logic [1:0] dbg [3];
    logic [2:0] s_prev = 3'b000;

    logic [5:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int HM = (g == 0) ? 8 : ((g == 1) ? 1 : 3);
        quad_mux_arbiter #(
            .HOLD_MAX (HM)
        ) u_dut (
            .CLK         (clk),
            .RST         (rst),
            .REQ_A       (req_a[g]),
            .REQ_B       (req_b[g]),
            .GNT_A       (gnt_a[g]),
            .GNT_B       (gnt_b[g]),
            .S           (s[g]),
            .E           (e[g]),
            .dbg_state_o (dbg[g])
        );
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // Drive one vector per cycle at the falling edge and queue the outputs expected after the next rising edge.
    task automatic step(input int sel, input logic ra, input logic rb, input logic [3:0] exp, input int n = 1);
        for (int i = 0; i < n; i++) begin
            req_a[sel] = ra;
            req_b[sel] = rb;
            exp_q.push_back({2'(sel), exp});
            @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        logic [5:0] item;
        logic [1:0] sel;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("excl_gnt[%0d]", g), {3'b000, gnt_a[g] & gnt_b[g]}, 4'd0);
            check($sformatf("e_vs_gnt[%0d]", g), {3'b000, e[g]}, {3'b000, ~(gnt_a[g] | gnt_b[g])});
            if (s[g] !== s_prev[g]) begin
                check($sformatf("s_toggle_enabled[%0d]", g), {3'b000, e[g]}, 4'd1);
            end
            s_prev[g] = s[g];
        end
        if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            sel  = item[5:4];
            check($sformatf("trace[%0d]", sel), {gnt_a[sel], gnt_b[sel], s[sel], e[sel]}, item[3:0]);
        end
    end

    initial begin
        rst   = 1'b1;
        req_a = 3'b000;
        req_b = 3'b000;
        #3;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset_out[%0d]", g), {gnt_a[g], gnt_b[g], s[g], e[g]}, X_S0);
            check($sformatf("reset_state[%0d]", g), {2'b00, dbg[g]}, {2'b00, IDLE});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request, then release
        step(0, 1'b1, 1'b0, X_S0);
        step(0, 1'b1, 1'b0, X_A, 2);
        step(0, 1'b0, 1'b0, X_S0, 2);

        // Early release: A owns, B waiting, A drops after its third grant cycle
        step(0, 1'b1, 1'b0, X_S0);
        step(0, 1'b1, 1'b0, X_A);
        step(0, 1'b1, 1'b1, X_A, 2);
        step(0, 1'b0, 1'b1, X_S1);
        step(0, 1'b0, 1'b1, X_B, 2);
        step(0, 1'b0, 1'b0, X_S1);

        // B pulses for one cycle: guard then back to idle, no grant
        step(0, 1'b0, 1'b1, X_S1);
        step(0, 1'b0, 1'b0, X_S1, 2);

        // Contention with HOLD_MAX=8: A wins the tie (last owner B)
        step(0, 1'b1, 1'b1, X_S0);
        step(0, 1'b1, 1'b1, X_A, 8);
        step(0, 1'b1, 1'b1, X_S1);
        step(0, 1'b1, 1'b1, X_B, 8);
        step(0, 1'b1, 1'b1, X_S0);
        step(0, 1'b1, 1'b1, X_A, 8);
        step(0, 1'b1, 1'b1, X_S1);
        step(0, 1'b1, 1'b1, X_B, 4);

        // Asynchronous reset in the middle of a B grant
        rst = 1'b1;
        #1;
        check("mid_reset_gnt_b", {3'b000, gnt_b[0]}, 4'd0);
        check("mid_reset_out", {gnt_a[0], gnt_b[0], s[0], e[0]}, X_S0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 1'b1, 1'b1, X_S0);
        step(0, 1'b1, 1'b1, X_A);
        step(0, 1'b0, 1'b0, X_S0);

        // HOLD_MAX=1: strict alternation
        step(1, 1'b1, 1'b1, X_S0);
        step(1, 1'b1, 1'b1, X_A);
        step(1, 1'b1, 1'b1, X_S1);
        step(1, 1'b1, 1'b1, X_B);
        step(1, 1'b1, 1'b1, X_S0);
        step(1, 1'b1, 1'b1, X_A);
        step(1, 1'b0, 1'b0, X_S0);

        // HOLD_MAX=3: three-cycle turns; A withdraws during the final guard
        step(2, 1'b1, 1'b1, X_S0);
        step(2, 1'b1, 1'b1, X_A, 3);
        step(2, 1'b1, 1'b1, X_S1);
        step(2, 1'b1, 1'b1, X_B, 3);
        step(2, 1'b1, 1'b1, X_S0);
        step(2, 1'b0, 1'b0, X_S0, 2);

        check("queue_drained", 4'(exp_q.size()), 4'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
